// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline-stage register with 2-entry skid buffer and flush
// Optional feature macro: PIPE_FLUSH_ZERO_EN (flush also zeroes the held payloads).
module pipe_stage_reg #(
  parameter int CTRL_W    = 5,
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 3,
  parameter int ADDR_W    = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CTRL_W-1:0]           in_ctrl,
  input  logic [NUM_WORDS*WORD_W-1:0] in_data,
  input  logic [ADDR_W-1:0]           in_addr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CTRL_W-1:0]           out_ctrl,
  output logic [NUM_WORDS*WORD_W-1:0] out_data,
  output logic [ADDR_W-1:0]           out_addr,
  output logic [1:0]                  occupancy
);

  localparam int DATA_W = NUM_WORDS * WORD_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [ADDR_W-1:0] main_addr_q, main_addr_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;

  logic accept;
  logic emit;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  // State and payload registers; reset clears everything without waiting for a clock edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      main_addr_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      main_addr_q <= main_addr_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_addr_q <= skid_addr_d;
    end
  end

  // Next-state: flush wins over every handshake and returns the stage to EMPTY
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !emit)      state_d = ST_FULL;
          else if (!accept && emit) state_d = ST_EMPTY;
        end
        ST_FULL:  if (emit) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Payload next values: main always holds the oldest beat, skid only the second one
  always_comb begin
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    main_addr_d = main_addr_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    skid_addr_d = skid_addr_q;
    if (flush) begin
`ifdef PIPE_FLUSH_ZERO_EN
      main_ctrl_d = '0;
      main_data_d = '0;
      main_addr_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
      skid_addr_d = '0;
`else
      // Stale payload is kept; consumers qualify everything with out_valid
      main_ctrl_d = main_ctrl_q;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            main_addr_d = in_addr;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            main_addr_d = in_addr;
          end else if (accept) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            skid_addr_d = in_addr;
          end
        end
        ST_FULL: begin
          if (emit) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            main_addr_d = skid_addr_q;
          end
        end
        default: begin
          main_ctrl_d = main_ctrl_q;
        end
      endcase
    end
  end

  // Handshake outputs decode the state register only, so in_ready never sees out_ready
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_q)
      ST_EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
      ST_ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      ST_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

  assign out_ctrl = main_ctrl_q;
  assign out_data = main_data_q;
  assign out_addr = main_addr_q;

endmodule
